// File: rtl/rmt_parse_pkg.sv
// rtl/rmt_parse_pkg.sv - shared parse-action field layout, container geometry and sequencer states
package rmt_parse_pkg;

   localparam int OFF_MSB   = 12;
   localparam int OFF_LSB   = 6;
   localparam int TYPE_MSB  = 5;
   localparam int TYPE_LSB  = 4;
   localparam int IDX_MSB   = 3;
   localparam int IDX_LSB   = 1;
   localparam int VALID_BIT = 0;

   localparam logic [1:0] T_NONE = 2'b00;
   localparam logic [1:0] T_2B   = 2'b01;
   localparam logic [1:0] T_4B   = 2'b10;
   localparam logic [1:0] T_6B   = 2'b11;

   localparam int W_2B = 16;
   localparam int W_4B = 32;
   localparam int W_6B = 48;

   localparam int NUM_SLOTS   = 8;
   localparam int PHV_2B_BASE = 0;
   localparam int PHV_4B_BASE = PHV_2B_BASE + NUM_SLOTS * W_2B;
   localparam int PHV_6B_BASE = PHV_4B_BASE + NUM_SLOTS * W_4B;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      OUTPUT
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [1:0] ctype;
      logic [2:0] index;
   } tag_t;

   function automatic logic [5:0] type_width(input logic [1:0] ctype);
      case (ctype)
         T_2B:    return 6'(W_2B);
         T_4B:    return 6'(W_4B);
         T_6B:    return 6'(W_6B);
         default: return 6'd0;
      endcase
   endfunction

   // An extraction is legal only if its last bit still lies inside the header window.
   function automatic logic in_bounds(input logic [6:0] off, input logic [1:0] ctype,
                                      input int hdr_len);
      logic [10:0] end_bit;
      end_bit = {1'b0, off, 3'b000} + {5'b00000, type_width(ctype)};
      return int'(end_bit) <= hdr_len;
   endfunction

endpackage

// File: rtl/sub_parser.sv
// rtl/sub_parser.sv - single-cycle byte-aligned field extractor shared by all parse actions
module sub_parser
   import rmt_parse_pkg::*;
#(
   parameter int HDR_FIELD_LEN      = 1024,
   parameter int VAL_LEN            = 48,
   parameter int C_PARSE_ACTION_LEN = 13
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          hdr_valid,
   input  logic [HDR_FIELD_LEN-1:0]      pkt_hdr_field,
   input  logic [C_PARSE_ACTION_LEN-1:0] parse_action,
   output logic [VAL_LEN-1:0]            val_out,
   output logic                          val_valid_out
);

   logic [HDR_FIELD_LEN-1:0] shifted;
   logic [VAL_LEN-1:0]       field;
   logic                     unused_bits;

   always_comb begin
      shifted = pkt_hdr_field >> {parse_action[OFF_MSB:OFF_LSB], 3'b000};
      field   = '0;
      case (parse_action[TYPE_MSB:TYPE_LSB])
         T_2B:    field = {{(VAL_LEN-W_2B){1'b0}}, shifted[W_2B-1:0]};
         T_4B:    field = {{(VAL_LEN-W_4B){1'b0}}, shifted[W_4B-1:0]};
         T_6B:    field = shifted[VAL_LEN-1:0];
         default: field = '0;
      endcase
   end

   assign unused_bits = ^{shifted[HDR_FIELD_LEN-1:VAL_LEN], parse_action[IDX_MSB:VALID_BIT]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_out       <= '0;
         val_valid_out <= 1'b0;
      end else begin
         val_valid_out <= hdr_valid;
         if (hdr_valid) begin
            val_out <= field;
         end
      end
   end

endmodule

// File: rtl/parse_action_sequencer.sv
// rtl/parse_action_sequencer.sv - walks a packet's parse actions through one shared extractor and assembles the PHV
module parse_action_sequencer
   import rmt_parse_pkg::*;
#(
   parameter int NUM_ACTIONS        = 10,
   parameter int ACT_SLOT_LEN       = 16,
   parameter int C_PARSE_ACTION_LEN = 13,
   parameter int HDR_FIELD_LEN      = 1024,
   parameter int VAL_LEN            = 48,
   parameter int PHV_LEN            = NUM_SLOTS * (W_6B + W_4B + W_2B)
) (
   input  logic                                axis_clk,
   input  logic                                aresetn,
   input  logic [HDR_FIELD_LEN-1:0]            pkt_hdr_field,
   input  logic [NUM_ACTIONS*ACT_SLOT_LEN-1:0] parse_actions,
   input  logic                                in_valid,
   output logic                                in_ready,
   output logic [PHV_LEN-1:0]                  phv_out,
   output logic                                parse_err,
   output logic                                phv_valid,
   input  logic                                phv_ready
);

   localparam int IDX_W = $clog2(NUM_ACTIONS);

   state_t                              state;
   state_t                              state_nxt;
   logic [IDX_W-1:0]                    idx;
   logic [HDR_FIELD_LEN-1:0]            hdr_q;
   logic [NUM_ACTIONS*ACT_SLOT_LEN-1:0] act_q;
   logic [PHV_LEN-1:0]                  phv_q;
   logic                                err_q;
   tag_t                                tag_q;
   tag_t                                tag_nxt;

   logic [C_PARSE_ACTION_LEN-1:0] act_cur;
   logic                          act_typed;
   logic                          act_ok;
   logic                          issue;
   logic                          accept;
   logic                          last_idx;
   logic [VAL_LEN-1:0]            val;
   logic                          val_valid;

   assign act_cur   = act_q[idx*ACT_SLOT_LEN +: C_PARSE_ACTION_LEN];
   assign act_typed = act_cur[VALID_BIT] && (act_cur[TYPE_MSB:TYPE_LSB] != T_NONE);
   assign act_ok    = in_bounds(act_cur[OFF_MSB:OFF_LSB], act_cur[TYPE_MSB:TYPE_LSB], HDR_FIELD_LEN);
   assign last_idx  = (idx == IDX_W'(NUM_ACTIONS - 1));

   assign in_ready  = (state == IDLE);
   assign phv_valid = (state == OUTPUT);
   assign accept    = in_valid && in_ready;
   assign phv_out   = phv_q;
   assign parse_err = err_q;

   sub_parser #(
      .HDR_FIELD_LEN      (HDR_FIELD_LEN),
      .VAL_LEN            (VAL_LEN),
      .C_PARSE_ACTION_LEN (C_PARSE_ACTION_LEN)
   ) u_sub_parser (
      .clk           (axis_clk),
      .rst_n         (aresetn),
      .hdr_valid     (issue),
      .pkt_hdr_field (hdr_q),
      .parse_action  (act_cur),
      .val_out       (val),
      .val_valid_out (val_valid)
   );

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      tag_nxt   = '0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = ISSUE;
         end
         ISSUE: begin
            issue         = act_typed && act_ok;
            tag_nxt.valid = issue;
            tag_nxt.ctype = act_cur[TYPE_MSB:TYPE_LSB];
            tag_nxt.index = act_cur[IDX_MSB:IDX_LSB];
            if (last_idx) state_nxt = DRAIN;
         end
         DRAIN: begin
            state_nxt = OUTPUT;
         end
         OUTPUT: begin
            if (phv_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The write uses only the registered tag: the extractor result lags its issue by one cycle.
   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         idx   <= '0;
         hdr_q <= '0;
         act_q <= '0;
         phv_q <= '0;
         err_q <= 1'b0;
         tag_q <= '0;
      end else begin
         tag_q <= tag_nxt;
         if (accept) begin
            hdr_q <= pkt_hdr_field;
            act_q <= parse_actions;
            phv_q <= '0;
            err_q <= 1'b0;
            idx   <= '0;
         end else begin
            if (state == ISSUE) begin
               if (act_typed && !act_ok) err_q <= 1'b1;
               if (!last_idx) idx <= idx + 1'b1;
            end
            if (val_valid && tag_q.valid) begin
               case (tag_q.ctype)
                  T_2B: phv_q[PHV_2B_BASE + W_2B*int'(tag_q.index) +: W_2B] <= val[W_2B-1:0];
                  T_4B: phv_q[PHV_4B_BASE + W_4B*int'(tag_q.index) +: W_4B] <= val[W_4B-1:0];
                  T_6B: phv_q[PHV_6B_BASE + W_6B*int'(tag_q.index) +: W_6B] <= val[W_6B-1:0];
                  default: ;
               endcase
            end
         end
      end
   end

endmodule
